shift_seq_ctrl: RTL and testbench

Sequencer for the serial shift-register datapath inside the `tt_um_*` top level. It accepts a parallel word over a valid/ready handshake and drives it out MSB-first on a serial line, one bit per programmable-rate shift strobe. On the same strobes it samples the serial return line into a capture register. When the transfer completes it presents the captured word over a second valid/ready handshake.

---
 rtl/shift_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: sends a parallel word MSB-first at a programmable strobe rate
// while capturing the return line, then hands the captured word back over valid/ready.
module shift_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int DIV_W = 8,
   parameter int LEN_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic             abort,
   output logic             sr_out,
   input  logic             sr_in,
   output logic             sr_shift,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_cap;
   logic [LEN_W-1:0] r_bitcnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_divcnt;
   logic [LEN_W-1:0] w_len;
   logic [LEN_W-1:0] w_shamt;
   logic             w_accept;
   logic             w_strobe;

   // Zero or oversize lengths both mean a full-width transfer.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
      if (l == '0 || l > LEN_W'(WIDTH))
         return LEN_W'(WIDTH);
      return l;
   endfunction

   assign w_len    = eff_len(cfg_len);
   assign w_shamt  = LEN_W'(WIDTH) - w_len;
   assign w_accept = (r_state == S_IDLE) && tx_valid && !abort;
   assign w_strobe = (r_state == S_SHIFT) && (r_divcnt == '0);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_SHIFT;
         S_SHIFT: begin
            if (abort)
               w_next = S_IDLE;
            else if (w_strobe && r_bitcnt == LEN_W'(1))
               w_next = S_DONE;
         end
         S_DONE:  if (abort || rx_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are forced low while reset is asserted, whatever the current state.
   always_comb begin
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      sr_out   = 1'b0;
      sr_shift = 1'b0;
      busy     = 1'b0;
      if (!rst) begin
         rx_data = r_cap;
         busy    = (r_state != S_IDLE);
         case (r_state)
            S_IDLE:  tx_ready = !abort;
            S_SHIFT: begin
               sr_out   = r_work[WIDTH-1];
               sr_shift = w_strobe;
            end
            S_DONE:  rx_valid = 1'b1;
            default: ;
         endcase
      end
   end

   // A strobe coinciding with abort still shifts; the state change discards the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work   <= '0;
         r_cap    <= '0;
         r_bitcnt <= '0;
         r_div    <= '0;
         r_divcnt <= '0;
      end else if (w_accept) begin
         r_work   <= tx_data << w_shamt;
         r_cap    <= '0;
         r_bitcnt <= w_len;
         r_div    <= cfg_div;
         r_divcnt <= cfg_div;
      end else if (r_state == S_SHIFT) begin
         if (w_strobe) begin
            r_work   <= r_work << 1;
            r_cap    <= {r_cap[WIDTH-2:0], sr_in};
            r_bitcnt <= r_bitcnt - LEN_W'(1);
            r_divcnt <= r_div;
         end else begin
            r_divcnt <= r_divcnt - DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: loopback, short/slow transfers, clamp, backpressure,
// abort and mid-transfer reset, with cycle numbers counted from the accept edge.
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cfg_div;
   logic [5:0]  cfg_len;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        abort;
   logic        sr_out;
   logic        sr_in;
   logic        sr_shift;
   logic        busy;
   logic        loop_en;
   logic        sr_in_drv;

   int n_tests = 0;
   int n_fail  = 0;

   assign sr_in = loop_en ? sr_out : sr_in_drv;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(32), .DIV_W(8), .LEN_W(6)) dut (
      .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_len(cfg_len),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .abort(abort), .sr_out(sr_out), .sr_in(sr_in), .sr_shift(sr_shift),
      .busy(busy)
   );

   // Inputs change just after the rising edge; outputs are read on the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input logic [31:0] d, input logic [5:0] len, input logic [7:0] div);
      cyc();
      tx_data  = d;
      cfg_len  = len;
      cfg_div  = div;
      tx_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain();
      cyc();
      rx_ready = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      cyc();
      rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int strobes;
      int rxv_cyc;
      rst = 1'b1; tx_valid = 1'b1; tx_data = 32'h1234_5678; cfg_len = 6'd40; cfg_div = 8'd0;
      rx_ready = 1'b0; abort = 1'b0; loop_en = 1'b1; sr_in_drv = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         @(negedge clk);
         n_tests++;
         if ({tx_ready, rx_valid, sr_out, sr_shift, busy} !== 5'b0 || rx_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs[%0d]: got ctl=%b data=%h, want ctl=00000 data=00000000",
                     i, {tx_ready, rx_valid, sr_out, sr_shift, busy}, rx_data);
         end
      end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, want 1", tx_ready);
      end
      strobes = 0; rxv_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         cyc();
         tx_valid = 1'b0;
         @(negedge clk);
         if (sr_shift === 1'b1) strobes++;
         if (rx_valid === 1'b1 && rxv_cyc < 0) rxv_cyc = c;
      end
      n_tests++;
      if (strobes != 32) begin
         n_fail++;
         $display("FAIL clamp_strobes: got %0d, want 32", strobes);
      end
      n_tests++;
      if (rxv_cyc != 33 || rx_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL clamp_result: got cycle %0d data %h, want cycle 33 data 12345678", rxv_cyc, rx_data);
      end
      drain();
   endtask

   task automatic test_loopback();
      int strobes;
      int first_s;
      int last_s;
      int rxv_cyc;
      loop_en = 1'b1;
      do_accept(32'hA5C3_0F01, 6'd0, 8'd0);
      strobes = 0; first_s = -1; last_s = -1; rxv_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         cyc();
         tx_valid = 1'b0;
         @(negedge clk);
         if (sr_shift === 1'b1) begin
            strobes++;
            if (first_s < 0) first_s = c;
            last_s = c;
         end
         if (rx_valid === 1'b1 && rxv_cyc < 0) rxv_cyc = c;
      end
      n_tests++;
      if (strobes != 32 || first_s != 1 || last_s != 32) begin
         n_fail++;
         $display("FAIL loop_strobes: got %0d strobes in %0d..%0d, want 32 in 1..32", strobes, first_s, last_s);
      end
      n_tests++;
      if (rxv_cyc != 33) begin
         n_fail++;
         $display("FAIL loop_rx_valid_cycle: got %0d, want 33", rxv_cyc);
      end
      n_tests++;
      if (rx_data !== 32'hA5C3_0F01) begin
         n_fail++;
         $display("FAIL loop_rx_data: got %h, want a5c30f01", rx_data);
      end
      drain();
   endtask

   task automatic test_short_slow();
      logic [4:0] pat;
      logic       exp_out;
      logic       exp_sh;
      pat = 5'b10110;
      loop_en = 1'b0; sr_in_drv = 1'b1;
      do_accept(32'hFFFF_FF16, 6'd5, 8'd3);
      for (int c = 1; c <= 20; c++) begin
         cyc();
         tx_valid = 1'b0;
         @(negedge clk);
         exp_out = pat[4 - (c - 1) / 4];
         exp_sh  = ((c % 4) == 0);
         n_tests++;
         if (sr_out !== exp_out || sr_shift !== exp_sh) begin
            n_fail++;
            $display("FAIL short_serial[c=%0d]: got out=%b shift=%b, want out=%b shift=%b",
                     c, sr_out, sr_shift, exp_out, exp_sh);
         end
      end
      cyc();
      @(negedge clk);
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 32'h0000_001F) begin
         n_fail++;
         $display("FAIL short_result: got valid=%b data=%h, want valid=1 data=0000001f", rx_valid, rx_data);
      end
      drain();
   endtask

   task automatic test_backpressure();
      loop_en = 1'b1;
      do_accept(32'h0000_00B4, 6'd8, 8'd1);
      for (int c = 1; c <= 16; c++) begin
         cyc();
         tx_valid = 1'b0;
         if (c == 3) begin
            cfg_div = 8'd5;
            cfg_len = 6'd3;
         end
         @(negedge clk);
         n_tests++;
         if (sr_shift !== ((c % 2) == 0)) begin
            n_fail++;
            $display("FAIL bp_strobe[c=%0d]: got %b, want %b", c, sr_shift, ((c % 2) == 0));
         end
      end
      for (int c = 17; c <= 26; c++) begin
         cyc();
         tx_valid = 1'b1;
         rx_ready = 1'b0;
         @(negedge clk);
         n_tests++;
         if (rx_valid !== 1'b1 || rx_data !== 32'h0000_00B4 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[c=%0d]: got valid=%b data=%h ready=%b, want valid=1 data=000000b4 ready=0",
                     c, rx_valid, rx_data, tx_ready);
         end
      end
      cyc();
      rx_ready = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (tx_ready !== 1'b0 || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_handshake: got ready=%b valid=%b, want ready=0 valid=1", tx_ready, rx_valid);
      end
      cyc();
      rx_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (tx_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_return_idle: got ready=%b busy=%b, want ready=1 busy=0", tx_ready, busy);
      end
   endtask

   task automatic test_abort();
      int strobes;
      loop_en = 1'b1;
      do_accept(32'h0000_00FF, 6'd8, 8'd1);
      strobes = 0;
      for (int c = 1; c <= 7; c++) begin
         cyc();
         tx_valid = 1'b0;
         abort = (c == 7);
         @(negedge clk);
         if (sr_shift === 1'b1) strobes++;
      end
      n_tests++;
      if (strobes != 3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: got %0d strobes busy=%b, want 3 strobes busy=1", strobes, busy);
      end
      for (int c = 8; c <= 12; c++) begin
         cyc();
         abort = 1'b1; tx_valid = 1'b1; tx_data = 32'h9; cfg_len = 6'd4; cfg_div = 8'd0;
         @(negedge clk);
         n_tests++;
         if ({busy, tx_ready, sr_shift, rx_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle[c=%0d]: got busy,ready,shift,valid=%b, want 0000",
                     c, {busy, tx_ready, sr_shift, rx_valid});
         end
      end
      cyc();
      abort = 1'b0;
      @(negedge clk);
      n_tests++;
      if (tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_release_ready: got %b, want 1", tx_ready);
      end
      strobes = 0;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         tx_valid = 1'b0;
         @(negedge clk);
         if (sr_shift === 1'b1) strobes++;
      end
      n_tests++;
      if (strobes != 4 || rx_valid !== 1'b1 || rx_data !== 32'h9) begin
         n_fail++;
         $display("FAIL abort_next_word: got %0d strobes valid=%b data=%h, want 4 valid=1 data=00000009",
                  strobes, rx_valid, rx_data);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      loop_en = 1'b1;
      do_accept(32'hFFFF_FFFF, 6'd0, 8'd0);
      for (int c = 1; c <= 5; c++) begin
         cyc();
         tx_valid = 1'b0;
         @(negedge clk);
      end
      cyc();
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({tx_ready, rx_valid, sr_out, sr_shift, busy} !== 5'b0 || rx_data !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got ctl=%b data=%h, want ctl=00000 data=00000000",
                  {tx_ready, rx_valid, sr_out, sr_shift, busy}, rx_data);
      end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || rx_data !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_idle: got busy=%b data=%h, want busy=0 data=00000000", busy, rx_data);
      end
      do_accept(32'h0000_0003, 6'd0, 8'd0);
      for (int c = 1; c <= 33; c++) begin
         cyc();
         tx_valid = 1'b0;
         @(negedge clk);
      end
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 32'h0000_0003) begin
         n_fail++;
         $display("FAIL midreset_next_word: got valid=%b data=%h, want valid=1 data=00000003", rx_valid, rx_data);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_short_slow();
      test_backpressure();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
